// File: rtl/mem_access_unit.sv
// Memory stage: runs loads/stores over a req/addr_ok/data_ok data bus and
// produces the registered writeback bundle (extended load data or ALU result).
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [3:0]            ex_mem_op,
  input  logic [ADDR_WIDTH-1:0] ex_mem_address,
  input  logic [31:0]           ex_store_data,
  input  logic                  ex_write_reg,
  input  logic [4:0]            ex_write_reg_address,
  input  logic [31:0]           ex_write_reg_data,
  input  logic                  ex_has_excep,
  input  logic [4:0]            ex_excep_code,
  input  logic [31:0]           ex_pc,
  output logic                  is_busbusy,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [31:0]           data_wdata,
  input  logic                  data_addr_ok,
  input  logic [31:0]           data_rdata,
  input  logic                  data_data_ok,
  output logic                  wb_we,
  output logic [4:0]            wb_reg_address,
  output logic [31:0]           wb_reg_data,
  output logic [4:0]            wb_excep_code,
  output logic [31:0]           wb_pc
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd9;
  localparam logic [3:0] OP_SH  = 4'd10;
  localparam logic [3:0] OP_SW  = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        op_valid;
  logic        start;
  logic        data_done;
  logic [1:0]  size_dec;
  logic [31:0] wdata_dec;
  logic [31:0] load_ext;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  logic [3:0]  lat_op;
  logic [4:0]  lat_reg_addr;
  logic        lat_we;
  logic [31:0] lat_pc;
  logic [4:0]  lat_excep_code;
  logic [31:0] rdata_q;

  always_comb begin
    op_valid = 1'b0;
    case (ex_mem_op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  end

  assign start      = (state == S_IDLE) & ex_valid & op_valid & ~ex_has_excep;
  assign is_busbusy = start | (state == S_REQ) | (state == S_WAIT);
  // Gated by reset so an in-flight request is withdrawn in the reset cycle itself.
  assign data_req   = (state == S_REQ) & ~reset;
  assign data_done  = ((state == S_REQ) & data_addr_ok & data_data_ok) |
                      ((state == S_WAIT) & data_data_ok);

  always_comb begin
    size_dec  = 2'd2;
    wdata_dec = ex_store_data;
    case (ex_mem_op)
      OP_LB, OP_LBU, OP_SB: begin
        size_dec  = 2'd0;
        wdata_dec = {4{ex_store_data[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        size_dec  = 2'd1;
        wdata_dec = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_byte = rdata_q[7:0];
    case (data_addr[1:0])
      2'd0: sel_byte = rdata_q[7:0];
      2'd1: sel_byte = rdata_q[15:8];
      2'd2: sel_byte = rdata_q[23:16];
      2'd3: sel_byte = rdata_q[31:24];
      default: ;
    endcase
    sel_half = data_addr[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (lat_op)
      OP_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_ext = {24'd0, sel_byte};
      OP_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_ext = {16'd0, sel_half};
      default: load_ext = rdata_q;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      S_REQ: begin
        if (data_addr_ok && data_data_ok) state_nxt = S_DONE;
        else if (data_addr_ok)            state_nxt = S_WAIT;
      end
      S_WAIT: if (data_data_ok) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      data_wr        <= 1'b0;
      data_size      <= '0;
      data_addr      <= '0;
      data_wdata     <= '0;
      lat_op         <= '0;
      lat_reg_addr   <= '0;
      lat_we         <= 1'b0;
      lat_pc         <= '0;
      lat_excep_code <= '0;
      rdata_q        <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        data_wr        <= ex_mem_op[3];
        data_size      <= size_dec;
        data_addr      <= ex_mem_address;
        data_wdata     <= wdata_dec;
        lat_op         <= ex_mem_op;
        lat_reg_addr   <= ex_write_reg_address;
        lat_we         <= ex_write_reg;
        lat_pc         <= ex_pc;
        lat_excep_code <= ex_excep_code;
      end
      if (data_done) rdata_q <= data_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we          <= 1'b0;
      wb_reg_address <= '0;
      wb_reg_data    <= '0;
      wb_excep_code  <= '0;
      wb_pc          <= '0;
    end else begin
      case (state)
        S_DONE: begin
          wb_we          <= data_wr ? 1'b0 : lat_we;
          wb_reg_address <= lat_reg_addr;
          wb_excep_code  <= lat_excep_code;
          wb_pc          <= lat_pc;
          if (!data_wr) wb_reg_data <= load_ext;
        end
        S_IDLE: begin
          if (ex_valid && !start) begin
            wb_we          <= ex_write_reg & ~ex_has_excep;
            wb_reg_address <= ex_write_reg_address;
            wb_reg_data    <= ex_write_reg_data;
            wb_excep_code  <= ex_excep_code;
            wb_pc          <= ex_pc;
          end else begin
            wb_we <= 1'b0;
          end
        end
        default: wb_we <= 1'b0;
      endcase
    end
  end

endmodule
